branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
EX-side partner of the gshare predictor: carries each fetched instruction's prediction metadata (pred_taken, pred_target, PHT index) from IF through ID into EX.
- At EX, compares the prediction with the real outcome and drives the predictor training port (ex_update_en, ex_actual_taken, pht_idx_ex).
- On a mispredict, raises the front-end redirect and the ID/IF flush.

Parameters:
- XLEN, 32, address/PC width.
- PHT_IDX_W, 8, PHT index width; must match the predictor.
- CNT_W, 32, width of the performance counters (only used with BRANCH_PERF_EN).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- if_valid  input  1  IF holds a real instruction this cycle.
- if_pc  input  XLEN  PC of the IF instruction.
- if_pred_taken  input  1  predictor MSB for if_pc.
- if_pred_target  input  XLEN  predicted target (BTB/decode); ignored when if_pred_taken=0.
- if_pht_idx  input  PHT_IDX_W  hashed index produced at IF.
- stall  input  1  pipeline hold; freezes the ID and EX metadata registers.
- ex_is_cond  input  1  EX instruction is a conditional branch.
- ex_is_jump  input  1  EX instruction is JAL/JALR.
- ex_cond_taken  input  1  condition result from the ALU.
- ex_target  input  XLEN  computed branch/jump target.
- ex_update_en  output  1  train the PHT and GHR this cycle.
- ex_actual_taken  output  1  real outcome.
- pht_idx_ex  output  PHT_IDX_W  index carried from IF.
- redirect_valid  output  1  mispredict; the front end must fetch redirect_pc next.
- redirect_pc  output  XLEN  correct next PC.
- flush  output  1  kill the instruction in IF and the one entering ID.
- perf_branches  output  CNT_W  resolved conditional branches (BRANCH_PERF_EN only).
- perf_mispred  output  CNT_W  mispredicts (BRANCH_PERF_EN only).

Behaviour:
- Reset (async): both metadata stages invalid, all fields 0. All outputs are 0 during and after reset until a valid EX entry arrives.
- Pipeline, each cycle with stall=0:
  - ID ← IF fields with valid=if_valid & ~flush.
  - EX ← ID with valid=ID.valid & ~flush.
- stall=1: ID and EX hold; nothing is captured from IF.
- Resolution is combinational in the EX cycle and qualified by EX.valid & ~stall:
  - actual_taken = ex_is_jump | (ex_is_cond & ex_cond_taken).
  - mispredict = (actual_taken != EX.pred_taken) | (actual_taken & EX.pred_taken & ex_target != EX.pred_target).
  - redirect_pc = actual_taken ? ex_target : EX.pc + 4. Addition wraps modulo 2^XLEN.
- Output gating:
  - ex_update_en = EX.valid & ex_is_cond & ~stall. Jumps never train.
  - ex_actual_taken and pht_idx_ex are driven whenever EX.valid; they are meaningful only when ex_update_en=1.
  - redirect_valid = flush = EX.valid & ~stall & mispredict.
  - A non-branch EX entry (ex_is_cond=ex_is_jump=0) predicted taken is a mispredict with redirect_pc=EX.pc+4.
- One-shot rule: a branch held in EX under stall trains and redirects exactly once, in the first cycle stall=0. Nothing is emitted during stall cycles.
- Flush effect: the cycle after redirect_valid, ID and EX are both invalid (ID was killed, the IF entry was blocked). No training or redirect follows from squashed entries.
- Back-to-back branches resolve on consecutive cycles, each with its own pht_idx.
- Reset mid-stall or mid-redirect: everything clears immediately; no pending update survives reset.

Optional Feature:
BRANCH_PERF_EN
- Defined:
  - perf_branches increments on every ex_update_en.
  - perf_mispred increments on every redirect_valid cycle (jumps included).
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package branch_pkg holds:
  - localparams XLEN=32 and PHT_IDX_W=8;
  - typedef struct packed bp_meta_t {valid, pc, pred_taken, pred_target, pht_idx};
  - the predictor's reset counter value (2'b01).
- Sub-module bp_meta_stage: one bp_meta_t register with stall-hold and flush-invalidate, instantiated for ID and EX.

Test Plan:
- Reset, then idle → all outputs 0; after reset release, EX.valid stays 0 until if_valid=1 has propagated two cycles.
- Correct not-taken: if_pc=0x100, pred=0, idx=0x3C; 2 cycles later ex_is_cond=1, cond_taken=0 → ex_update_en=1, actual=0, pht_idx_ex=0x3C, redirect_valid=0.
- Mispredict taken: pc=0x200, pred=0; EX cond_taken=1, ex_target=0x180 → redirect_valid=flush=1, redirect_pc=0x180, update=1; next cycle ID and EX invalid, update=0.
- Wrong target: pred_taken=1, pred_target=0x400; EX jump with target=0x404 → redirect to 0x404, ex_update_en=0.
- Stall on a resolving branch for 3 cycles → no update or redirect during stall; exactly one update pulse when stall drops.
- With BRANCH_PERF_EN: 5 conditional branches, 2 mispredicted → perf_branches=5, perf_mispred=2; without the macro both read 0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and constants for the branch-resolution slice.
//                It holds the widths that must match the gshare predictor,
//                the per-instruction prediction metadata record, and the
//                predictor's counter reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam int XLEN      = 32;
    localparam int PHT_IDX_W = 8;

    // PHT entries come out of reset weakly not-taken.
    localparam logic [1:0] PHT_RESET_CNT = 2'b01;

    // Prediction metadata that travels with an instruction from IF to EX.
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic                 pred_taken;
        logic [XLEN-1:0]      pred_target;
        logic [PHT_IDX_W-1:0] pht_idx;
    } bp_meta_t;

    // Fall-through address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] seq_next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_if
//  Description : Signal bundle between the pipeline and branch_resolve.
//                master : pipeline side (drives IF/EX inputs and stall)
//                slave  : branch_resolve side (drives training, redirect,
//                         flush and performance counters)
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_if #(
    parameter int XLEN      = branch_pkg::XLEN,
    parameter int PHT_IDX_W = branch_pkg::PHT_IDX_W,
    parameter int CNT_W     = 32
);
    // IF side
    logic                 if_valid;
    logic [XLEN-1:0]      if_pc;
    logic                 if_pred_taken;
    logic [XLEN-1:0]      if_pred_target;
    logic [PHT_IDX_W-1:0] if_pht_idx;
    // pipeline control
    logic                 stall;
    // EX side
    logic                 ex_is_cond;
    logic                 ex_is_jump;
    logic                 ex_cond_taken;
    logic [XLEN-1:0]      ex_target;
    // results
    logic                 ex_update_en;
    logic                 ex_actual_taken;
    logic [PHT_IDX_W-1:0] pht_idx_ex;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 flush;
    logic [CNT_W-1:0]     perf_branches;
    logic [CNT_W-1:0]     perf_mispred;

    modport master (
        output if_valid, if_pc, if_pred_taken, if_pred_target, if_pht_idx,
        output stall,
        output ex_is_cond, ex_is_jump, ex_cond_taken, ex_target,
        input  ex_update_en, ex_actual_taken, pht_idx_ex,
        input  redirect_valid, redirect_pc, flush,
        input  perf_branches, perf_mispred
    );

    modport slave (
        input  if_valid, if_pc, if_pred_taken, if_pred_target, if_pht_idx,
        input  stall,
        input  ex_is_cond, ex_is_jump, ex_cond_taken, ex_target,
        output ex_update_en, ex_actual_taken, pht_idx_ex,
        output redirect_valid, redirect_pc, flush,
        output perf_branches, perf_mispred
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_bp_meta_stage.sv
`default_nettype none
// ============================================================================
//  Module      : bp_meta_stage
//  Description : One pipeline register of prediction metadata.
//                clk, rst (async, active-high)
//                stall : hold the current contents
//                flush : capture, but mark the captured entry invalid
//                d / q : metadata in / out
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_meta_stage
    import branch_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     stall,
    input  wire logic     flush,
    input  wire bp_meta_t d,
    output bp_meta_t      q
);

    bp_meta_t next_q;

    always_comb begin
        next_q       = d;
        next_q.valid = d.valid & ~flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (!stall) begin
            q <= next_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : EX-side partner of the gshare predictor. Carries prediction
//                metadata IF -> ID -> EX, compares it with the real outcome
//                in EX, drives the PHT/GHR training port and raises the
//                front-end redirect plus the IF/ID flush on a mispredict.
//  Ports       : clk, rst (async, active-high), bus (branch_resolve_if.slave)
//  Options     : BRANCH_PERF_EN - adds saturating resolved-branch and
//                mispredict counters; otherwise perf outputs read 0.
//  Note        : XLEN / PHT_IDX_W must equal the branch_pkg values, since
//                the metadata record is sized by the package.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int XLEN      = branch_pkg::XLEN,
    parameter int PHT_IDX_W = branch_pkg::PHT_IDX_W,
    parameter int CNT_W     = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    branch_resolve_if.slave  bus
);
    import branch_pkg::*;

    bp_meta_t if_meta;
    bp_meta_t id_meta;
    bp_meta_t ex_meta;

    logic            ex_fire;
    logic            actual_taken;
    logic            mispredict;
    logic            redirect;
    logic [XLEN-1:0] correct_pc;

    assign if_meta = '{
        valid:       bus.if_valid,
        pc:          bus.if_pc,
        pred_taken:  bus.if_pred_taken,
        pred_target: bus.if_pred_target,
        pht_idx:     bus.if_pht_idx
    };

    // ID kills what IF hands over on a redirect; EX kills the entry leaving
    // ID. Both therefore read as invalid the cycle after a redirect.
    bp_meta_stage u_id_stage (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stall),
        .flush (redirect),
        .d     (if_meta),
        .q     (id_meta)
    );

    bp_meta_stage u_ex_stage (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stall),
        .flush (redirect),
        .d     (id_meta),
        .q     (ex_meta)
    );

    // Qualifying with ~stall makes a held branch act only in its first
    // unstalled cycle; the stage then advances, so it cannot act again.
    assign ex_fire      = ex_meta.valid & ~bus.stall;
    assign actual_taken = bus.ex_is_jump | (bus.ex_is_cond & bus.ex_cond_taken);

    // Taken-vs-taken still mispredicts when the predicted target is wrong.
    assign mispredict = (actual_taken != ex_meta.pred_taken) |
                        (actual_taken & ex_meta.pred_taken &
                         (bus.ex_target != ex_meta.pred_target));

    assign correct_pc = actual_taken ? bus.ex_target : seq_next_pc(ex_meta.pc);
    assign redirect   = ex_fire & mispredict;

    // Only conditional branches train; jumps would pollute the GHR/PHT.
    assign bus.ex_update_en    = ex_fire & bus.ex_is_cond;
    assign bus.ex_actual_taken = ex_meta.valid & actual_taken;
    assign bus.pht_idx_ex      = ex_meta.valid ? ex_meta.pht_idx : '0;
    assign bus.redirect_valid  = redirect;
    assign bus.flush           = redirect;
    assign bus.redirect_pc     = ex_meta.valid ? correct_pc : '0;

`ifdef BRANCH_PERF_EN
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (bus.ex_update_en && (branch_cnt != {CNT_W{1'b1}})) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (redirect && (mispred_cnt != {CNT_W{1'b1}})) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.perf_branches = branch_cnt;
    assign bus.perf_mispred  = mispred_cnt;
`else
    assign bus.perf_branches = {CNT_W{1'b0}};
    assign bus.perf_mispred  = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Self-checking bench for branch_resolve. Table of isolated
//                branch vectors plus hand-written sequences for reset,
//                propagation latency, back-to-back resolution, stall
//                one-shot, flush squashing and performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    logic clk;
    logic rst;

    branch_resolve_if #(.XLEN(32), .PHT_IDX_W(8), .CNT_W(32)) bus ();

    branch_resolve #(.XLEN(32), .PHT_IDX_W(8), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic [7:0]  idx;
        logic        cond;
        logic        jump;
        logic        ct;
        logic [31:0] tgt;
        logic        upd;
        logic        act;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   exp_br   = 0;
    int   exp_mp   = 0;
    vec_t sb[$];
    vec_t tbl[10];
    vec_t bb[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_if(input vec_t v, input bit push);
        bus.if_valid       = 1'b1;
        bus.if_pc          = v.pc;
        bus.if_pred_taken  = v.pt;
        bus.if_pred_target = v.ptgt;
        bus.if_pht_idx     = v.idx;
        if (push) sb.push_back(v);
    endtask

    task automatic idle_if();
        bus.if_valid = 1'b0;
    endtask

    task automatic drive_ex(input vec_t v);
        bus.ex_is_cond    = v.cond;
        bus.ex_is_jump    = v.jump;
        bus.ex_cond_taken = v.ct;
        bus.ex_target     = v.tgt;
    endtask

    task automatic clear_ex();
        bus.ex_is_cond    = 1'b0;
        bus.ex_is_jump    = 1'b0;
        bus.ex_cond_taken = 1'b0;
        bus.ex_target     = '0;
    endtask

    // Pop the expected record for the instruction now in EX and compare.
    task automatic check_ex(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_update"}, {31'd0, bus.ex_update_en}, {31'd0, e.upd});
        check({tag, "_actual"}, {31'd0, bus.ex_actual_taken}, {31'd0, e.act});
        check({tag, "_idx"}, {24'd0, bus.pht_idx_ex}, {24'd0, e.idx});
        check({tag, "_redirect"}, {31'd0, bus.redirect_valid}, {31'd0, e.rv});
        check({tag, "_flush"}, {31'd0, bus.flush}, {31'd0, e.rv});
        if (e.rv) check({tag, "_rpc"}, bus.redirect_pc, e.rpc);
        exp_br += int'(e.upd);
        exp_mp += int'(e.rv);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_update"}, {31'd0, bus.ex_update_en}, 32'd0);
        check({tag, "_redirect"}, {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input vec_t v, input string tag);
        set_if(v, 1'b1);
        clear_ex();
        tick();
        idle_if();
        tick();
        drive_ex(v);
        @(negedge clk);
        check_ex(tag);
        tick();
        clear_ex();
        @(negedge clk);
        check_quiet({tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vec_t b;
        vec_t c;

        //            pc           pt    ptgt         idx    cond  jump  ct    tgt          upd   act   rv    rpc
        tbl[0] = '{32'h0000_0100, 1'b0, 32'h0,        8'h3C, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{32'h0000_0200, 1'b0, 32'h0,        8'h11, 1'b1, 1'b0, 1'b1, 32'h0000_0180, 1'b1, 1'b1, 1'b1, 32'h0000_0180};
        tbl[2] = '{32'h0000_0300, 1'b1, 32'h0000_0400, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0000_0404, 1'b0, 1'b1, 1'b1, 32'h0000_0404};
        tbl[3] = '{32'h0000_0500, 1'b1, 32'h0000_0600, 8'h55, 1'b1, 1'b0, 1'b1, 32'h0000_0600, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{32'h0000_0700, 1'b1, 32'h0000_0800, 8'h77, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 1'b1, 1'b0, 1'b1, 32'h0000_0704};
        tbl[5] = '{32'h0000_0900, 1'b1, 32'h0000_0A00, 8'h99, 1'b0, 1'b0, 1'b0, 32'h0000_0A00, 1'b0, 1'b0, 1'b1, 32'h0000_0904};
        tbl[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 8'hFF, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        tbl[7] = '{32'h0000_0B00, 1'b0, 32'h0,        8'h0B, 1'b0, 1'b1, 1'b0, 32'h0000_0C00, 1'b0, 1'b1, 1'b1, 32'h0000_0C00};
        tbl[8] = '{32'h0000_0D00, 1'b0, 32'h0,        8'h0D, 1'b0, 1'b0, 1'b0, 32'h0000_0E00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9] = '{32'h0000_0E00, 1'b1, 32'h0000_0F00, 8'h0E, 1'b0, 1'b1, 1'b0, 32'h0000_0F00, 1'b0, 1'b1, 1'b0, 32'h0};

        // correctly predicted, back-to-back, each with its own index
        bb[0] = '{32'h0000_1100, 1'b0, 32'h0,        8'hA1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 32'h0};
        bb[1] = '{32'h0000_1104, 1'b1, 32'h0000_3000, 8'hA2, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 32'h0};
        bb[2] = '{32'h0000_1108, 1'b0, 32'h0,        8'hA3, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 1'b1, 1'b0, 1'b0, 32'h0};
        bb[3] = '{32'h0000_110C, 1'b1, 32'h0000_5000, 8'hA4, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 1'b1, 1'b1, 1'b0, 32'h0};

        rst = 1'b1;
        bus.stall = 1'b0;
        idle_if();
        bus.if_pc = '0;
        bus.if_pred_taken = 1'b0;
        bus.if_pred_target = '0;
        bus.if_pht_idx = '0;
        clear_ex();

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_update", {31'd0, bus.ex_update_en}, 32'd0);
        check("rst_actual", {31'd0, bus.ex_actual_taken}, 32'd0);
        check("rst_idx", {24'd0, bus.pht_idx_ex}, 32'd0);
        check("rst_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        check("rst_rpc", bus.redirect_pc, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_perf_br", bus.perf_branches, 32'd0);
        check("rst_perf_mp", bus.perf_mispred, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check_quiet("idle");

        // ---- two-cycle propagation: non-branch predicted taken ----
        v = '{32'h0000_0040, 1'b1, 32'h0000_0080, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0044};
        tick();
        set_if(v, 1'b1);
        tick();
        idle_if();
        @(negedge clk);
        check("prop_id_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        tick();
        @(negedge clk);
        check_ex("prop_ex");
        tick();

        // ---- reset asserted while a branch is held in EX ----
        v = '{32'h0000_0600, 1'b0, 32'h0, 8'h66, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 1'b1, 1'b1, 1'b1, 32'h0000_0700};
        set_if(v, 1'b1);
        tick();
        idle_if();
        tick();
        drive_ex(v);
        bus.stall = 1'b1;
        @(negedge clk);
        check_quiet("mid_stall");
        check("mid_stall_actual", {31'd0, bus.ex_actual_taken}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_actual", {31'd0, bus.ex_actual_taken}, 32'd0);
        check("async_rst_idx", {24'd0, bus.pht_idx_ex}, 32'd0);
        check("async_rst_perf_mp", bus.perf_mispred, 32'd0);
        sb.delete();
        exp_br = 0;
        exp_mp = 0;
        tick();
        rst = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");
        tick();
        clear_ex();

        // ---- table of isolated vectors ----
        for (int i = 0; i < 10; i++) begin
            run_one(tbl[i], $sformatf("vec%0d", i));
        end
        tick();

        // ---- back-to-back resolution ----
        for (int k = 0; k < 6; k++) begin
            if (k < 4) set_if(bb[k], 1'b1);
            else idle_if();
            if (k >= 2) drive_ex(bb[k-2]);
            else clear_ex();
            @(negedge clk);
            if (k >= 2) check_ex($sformatf("b2b%0d", k - 2));
            tick();
        end
        clear_ex();

        // ---- stall on a resolving branch: exactly one update ----
        v = '{32'h0000_1000, 1'b1, 32'h0000_2000, 8'h5A, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0, 32'h0};
        c = '{32'h0000_3000, 1'b1, 32'h0000_3100, 8'hC3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        set_if(v, 1'b1);
        tick();
        idle_if();
        tick();
        drive_ex(v);
        bus.stall = 1'b1;
        set_if(c, 1'b0);  // must not be captured while stalled
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_quiet($sformatf("stall%0d", s));
            tick();
        end
        bus.stall = 1'b0;
        idle_if();
        @(negedge clk);
        check_ex("stall_release");
        tick();
        clear_ex();
        @(negedge clk);
        check_quiet("stall_once");
        tick();
        @(negedge clk);
        check_quiet("stall_no_leak");
        tick();

        // ---- flush squashes the two younger entries ----
        v = '{32'h0000_4000, 1'b0, 32'h0, 8'h41, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 1'b1, 1'b1, 1'b1, 32'h0000_5000};
        b = '{32'h0000_4004, 1'b1, 32'h0000_9000, 8'h42, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        c = '{32'h0000_4008, 1'b1, 32'h0000_9100, 8'h43, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        set_if(v, 1'b1);
        tick();
        set_if(b, 1'b0);
        tick();
        set_if(c, 1'b0);
        drive_ex(v);
        @(negedge clk);
        check_ex("flush_src");
        tick();
        idle_if();
        bus.ex_is_cond = 1'b1;
        bus.ex_cond_taken = 1'b0;
        bus.ex_target = 32'h0000_0123;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            check_quiet($sformatf("squashed%0d", s));
            check($sformatf("squashed%0d_actual", s), {31'd0, bus.ex_actual_taken}, 32'd0);
            tick();
        end
        clear_ex();
        tick();

        // ---- performance counters ----
        @(negedge clk);
`ifdef BRANCH_PERF_EN
        check("perf_branches", bus.perf_branches, 32'(exp_br));
        check("perf_mispred", bus.perf_mispred, 32'(exp_mp));
`else
        check("perf_branches_off", bus.perf_branches, 32'd0);
        check("perf_mispred_off", bus.perf_mispred, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
